display_arbiter: RTL and testbench



---
 rtl/display_arbiter_if.sv | 41 ++++
 rtl/display_arbiter.sv | 148 ++++++++++++++
 tb/tb_display_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_arbiter_if.sv
// ---------------------------------------------------------------------------
// display_arbiter_if
// Bundles the request/data side and the display side of the display
// arbiter into one connection.
//
// Signals:
//   req    [2:0]  request per source, req[2] highest priority
//   data0  [15:0] digit word of source 0
//   data1  [15:0] digit word of source 1
//   data2  [15:0] digit word of source 2
//   blink  [2:0]  per-source blink enable
//   nums   [15:0] registered digit word to the display
//   grant  [2:0]  one-hot current grant, 0 = idle
//   blank         1 = display must be blanked
//   switch        one-cycle pulse after any grant change
//
// Modports:
//   master  game-logic side: drives requests, data and blink enables
//   slave   arbiter side: drives nums, grant, blank and switch
// ---------------------------------------------------------------------------
interface display_arbiter_if;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [2:0]  blink;
    logic [15:0] nums;
    logic [2:0]  grant;
    logic        blank;
    logic        switch;

    modport master (
        output req, data0, data1, data2, blink,
        input  nums, grant, blank, switch
    );

    modport slave (
        input  req, data0, data1, data2, blink,
        output nums, grant, blank, switch
    );
endinterface

// File: rtl/display_arbiter.sv
// ---------------------------------------------------------------------------
// display_arbiter
// Shares the single 4-digit seven-segment display path between three
// requesters (score, high-score flash, status message). Each grant is held
// on screen for at least HOLD_CYCLES cycles, then arbitration resumes with
// fixed priority (source 2 highest). An optional per-source blink blanks the
// display every other BLINK_CYCLES-long half-period.
//
// Parameters:
//   HOLD_CYCLES   minimum cycles a grant is held (>=1)
//   BLINK_CYCLES  cycles per blink half-period (>=1)
//
// Ports:
//   clk   system clock
//   clr   asynchronous active-high reset
//   bus   display_arbiter_if.slave (req/data/blink in, nums/grant/blank/
//         switch out, all outputs registered)
// ---------------------------------------------------------------------------
module display_arbiter #(
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic              clk,
    input  logic              clr,
    display_arbiter_if.slave  bus
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        OPEN
    } state_t;

    state_t        state, next_state;
    logic [2:0]    grant_q, next_grant, arb;
    logic [TW-1:0] timer, next_timer;
    logic [BW-1:0] blink_cnt, next_cnt;
    logic          phase, next_phase;
    logic [15:0]   nums_q, next_nums;
    logic          blank_q, next_blank;
    logic          switch_q;
    logic          decide;
    logic          grant_change;

    // Fixed-priority pick: highest-indexed asserted request wins.
    always_comb begin
        arb = 3'b000;
        if (bus.req[2])
            arb = 3'b100;
        else if (bus.req[1])
            arb = 3'b010;
        else if (bus.req[0])
            arb = 3'b001;
    end

    // Grant/state decision. Arbitration only runs once the hold timer has
    // run out (HOLD with timer==0) or every edge while OPEN; until then the
    // grant is frozen even if its request has been dropped.
    always_comb begin
        next_state = state;
        next_grant = grant_q;
        next_timer = timer;
        decide     = (state == OPEN) || (state == HOLD && timer == '0);
        if (state == IDLE) begin
            if (arb != 3'b000) begin
                next_state = HOLD;
                next_grant = arb;
                next_timer = HOLD_LOAD;
            end
        end else if (!decide) begin
            next_timer = timer - TW'(1);
        end else if (arb == grant_q) begin
            next_state = OPEN;
        end else if (arb != 3'b000) begin
            next_state = HOLD;
            next_grant = arb;
            next_timer = HOLD_LOAD;
        end else begin
            next_state = IDLE;
            next_grant = 3'b000;
        end
    end

    // Blink counter and phase restart on every grant change so that freshly
    // granted content always starts in the visible half-period.
    always_comb begin
        grant_change = (next_grant != grant_q);
        next_cnt     = blink_cnt;
        next_phase   = phase;
        if (grant_change) begin
            next_cnt   = '0;
            next_phase = 1'b0;
        end else if (grant_q != 3'b000) begin
            if (blink_cnt == BLINK_LAST) begin
                next_cnt   = '0;
                next_phase = ~phase;
            end else begin
                next_cnt = blink_cnt + BW'(1);
            end
        end
    end

    // Display word and blank are computed from the next-state grant so they
    // line up with the grant register; source data is passed live.
    always_comb begin
        case (next_grant)
            3'b001:  next_nums = bus.data0;
            3'b010:  next_nums = bus.data1;
            3'b100:  next_nums = bus.data2;
            default: next_nums = 16'h0000;
        endcase
        next_blank = (next_grant == 3'b000) ||
                     ((|(bus.blink & next_grant)) && next_phase);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            grant_q   <= 3'b000;
            timer     <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            nums_q    <= 16'h0000;
            blank_q   <= 1'b1;
            switch_q  <= 1'b0;
        end else begin
            state     <= next_state;
            grant_q   <= next_grant;
            timer     <= next_timer;
            blink_cnt <= next_cnt;
            phase     <= next_phase;
            nums_q    <= next_nums;
            blank_q   <= next_blank;
            switch_q  <= grant_change;
        end
    end

    assign bus.nums   = nums_q;
    assign bus.grant  = grant_q;
    assign bus.blank  = blank_q;
    assign bus.switch = switch_q;

endmodule

// File: tb/tb_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_display_arbiter
// Self-checking bench for display_arbiter with HOLD_CYCLES=4, BLINK_CYCLES=3.
// A vector table covers single-pulse hold, priority with all requests held
// and no-preemption; hand sequences cover blink, live data and async reset;
// a randomized phase compares against an age-based reference model.
// ---------------------------------------------------------------------------
module tb_display_arbiter;

    localparam int HOLD  = 4;
    localparam int BLINK = 3;
    localparam logic [15:0] D0 = 16'hA000;
    localparam logic [15:0] D1 = 16'h1234;
    localparam logic [15:0] D2 = 16'hC0DE;

    logic clk;
    logic clr;
    int   total;
    int   bad;

    display_arbiter_if bus();

    display_arbiter #(
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  g;
        logic [15:0] n;
        logic        b;
        logic        s;
    } vec_t;

    vec_t tbl[20];

    // Reference model state: current grant and edges since it last changed.
    logic [2:0] m_grant;
    int         m_age;
    logic [2:0] e_grant;
    logic [15:0] e_nums;
    logic       e_blank;
    logic       e_switch;

    // Drive inputs away from the edge, then sample just after the edge.
    task automatic applyStimulus(input logic [2:0] req, input logic [15:0] d0,
                                 input logic [15:0] d1, input logic [15:0] d2,
                                 input logic [2:0] bl);
        @(negedge clk);
        bus.req   = req;
        bus.data0 = d0;
        bus.data1 = d1;
        bus.data2 = d2;
        bus.blink = bl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] g,
                               input logic [15:0] n, input logic b,
                               input logic s);
        total++;
        if (bus.grant !== g) begin
            bad++;
            $display("[TB] FAIL %s grant got=%b want=%b", name, bus.grant, g);
        end
        total++;
        if (bus.nums !== n) begin
            bad++;
            $display("[TB] FAIL %s nums got=%h want=%h", name, bus.nums, n);
        end
        total++;
        if (bus.blank !== b) begin
            bad++;
            $display("[TB] FAIL %s blank got=%b want=%b", name, bus.blank, b);
        end
        total++;
        if (bus.switch !== s) begin
            bad++;
            $display("[TB] FAIL %s switch got=%b want=%b", name, bus.switch, s);
        end
    endtask

    // Assert reset between edges and confirm it acts without a clock edge.
    task automatic resetDut(input string name);
        @(negedge clk);
        clr = 1'b1;
        #1;
        checkOutput(name, 3'b000, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        clr = 1'b0;
    endtask

    function automatic logic [2:0] top_req(input logic [2:0] r);
        if (r[2]) return 3'b100;
        if (r[1]) return 3'b010;
        if (r[0]) return 3'b001;
        return 3'b000;
    endfunction

    // Model rule: a grant may change only once HOLD edges have passed since
    // it was issued; from then on the top request decides. Blink phase is
    // the parity of (edges since change) / BLINK.
    task automatic modelEdge(input logic [2:0] req, input logic [15:0] d0,
                             input logic [15:0] d1, input logic [15:0] d2,
                             input logic [2:0] bl);
        logic [2:0] a;
        logic       changed;
        a       = top_req(req);
        changed = 1'b0;
        if (m_grant == 3'b000) begin
            if (a != 3'b000) begin
                m_grant = a;
                changed = 1'b1;
            end
        end else if (m_age + 1 >= HOLD) begin
            if (a != m_grant) begin
                m_grant = a;
                changed = 1'b1;
            end
        end
        if (changed) m_age = 0;
        else         m_age = m_age + 1;
        e_grant  = m_grant;
        e_switch = changed;
        e_nums   = (m_grant == 3'b001) ? d0 :
                   (m_grant == 3'b010) ? d1 :
                   (m_grant == 3'b100) ? d2 : 16'h0000;
        e_blank  = (m_grant == 3'b000) ||
                   ((|(bl & m_grant)) && (((m_age / BLINK) % 2) == 1));
    endtask

    initial begin
        logic [2:0]  r;
        logic [15:0] d0, d1, d2;
        logic [2:0]  bl;
        logic        pat[8];

        total     = 0;
        bad       = 0;
        clr       = 1'b0;
        bus.req   = 3'b000;
        bus.data0 = D0;
        bus.data1 = D1;
        bus.data2 = D2;
        bus.blink = 3'b000;

        // Single pulse on source 1, then all requests, then no-preemption.
        tbl[0]  = '{3'b010, 3'b010, D1, 1'b0, 1'b1};
        tbl[1]  = '{3'b000, 3'b010, D1, 1'b0, 1'b0};
        tbl[2]  = '{3'b000, 3'b010, D1, 1'b0, 1'b0};
        tbl[3]  = '{3'b000, 3'b010, D1, 1'b0, 1'b0};
        tbl[4]  = '{3'b000, 3'b000, 16'h0000, 1'b1, 1'b1};
        tbl[5]  = '{3'b000, 3'b000, 16'h0000, 1'b1, 1'b0};
        tbl[6]  = '{3'b111, 3'b100, D2, 1'b0, 1'b1};
        tbl[7]  = '{3'b111, 3'b100, D2, 1'b0, 1'b0};
        tbl[8]  = '{3'b111, 3'b100, D2, 1'b0, 1'b0};
        tbl[9]  = '{3'b111, 3'b100, D2, 1'b0, 1'b0};
        tbl[10] = '{3'b111, 3'b100, D2, 1'b0, 1'b0};
        tbl[11] = '{3'b111, 3'b100, D2, 1'b0, 1'b0};
        tbl[12] = '{3'b111, 3'b100, D2, 1'b0, 1'b0};
        tbl[13] = '{3'b000, 3'b000, 16'h0000, 1'b1, 1'b1};
        tbl[14] = '{3'b001, 3'b001, D0, 1'b0, 1'b1};
        tbl[15] = '{3'b101, 3'b001, D0, 1'b0, 1'b0};
        tbl[16] = '{3'b101, 3'b001, D0, 1'b0, 1'b0};
        tbl[17] = '{3'b101, 3'b001, D0, 1'b0, 1'b0};
        tbl[18] = '{3'b101, 3'b100, D2, 1'b0, 1'b1};
        tbl[19] = '{3'b101, 3'b100, D2, 1'b0, 1'b0};

        resetDut("reset_initial");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(tbl[i].req, D0, D1, D2, 3'b000);
            checkOutput($sformatf("vec%0d", i), tbl[i].g, tbl[i].n,
                        tbl[i].b, tbl[i].s);
        end

        // Blink on source 0, then blink disabled while still granted.
        bus.req = 3'b000;
        resetDut("reset_blink");
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'b001, D0, D1, D2, 3'b001);
            checkOutput($sformatf("blink_on%0d", i), 3'b001, D0, pat[i],
                        (i == 0));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b001, D0, D1, D2, 3'b000);
            checkOutput($sformatf("blink_off%0d", i), 3'b001, D0, 1'b0, 1'b0);
        end

        // Live data on source 1.
        bus.req = 3'b000;
        resetDut("reset_data");
        applyStimulus(3'b010, D0, 16'h0001, D2, 3'b000);
        checkOutput("data_first", 3'b010, 16'h0001, 1'b0, 1'b1);
        applyStimulus(3'b010, D0, 16'h0001, D2, 3'b000);
        checkOutput("data_hold", 3'b010, 16'h0001, 1'b0, 1'b0);
        applyStimulus(3'b010, D0, 16'h0002, D2, 3'b000);
        checkOutput("data_change", 3'b010, 16'h0002, 1'b0, 1'b0);

        // Reset in the middle of a hold, then a full fresh hold.
        bus.req = 3'b000;
        resetDut("reset_pre_mid");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b001, D0, D1, D2, 3'b000);
            checkOutput($sformatf("mid_hold%0d", i), 3'b001, D0, 1'b0,
                        (i == 0));
        end
        #2;
        clr = 1'b1;
        #1;
        checkOutput("mid_reset", 3'b000, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("after_reset_grant", 3'b001, D0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b100, D0, D1, D2, 3'b000);
            checkOutput($sformatf("after_reset_hold%0d", i), 3'b001, D0,
                        1'b0, 1'b0);
        end
        applyStimulus(3'b100, D0, D1, D2, 3'b000);
        checkOutput("after_reset_regrant", 3'b100, D2, 1'b0, 1'b1);

        // Randomized traffic against the reference model.
        bus.req = 3'b000;
        resetDut("reset_random");
        m_grant = 3'b000;
        m_age   = 0;
        r  = 3'b000;
        d0 = D0;
        d1 = D1;
        d2 = D2;
        bl = 3'b000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) d0 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d2 = 16'($urandom);
            if ($urandom_range(0, 7) == 0) bl = 3'($urandom_range(0, 7));
            modelEdge(r, d0, d1, d2, bl);
            applyStimulus(r, d0, d1, d2, bl);
            checkOutput($sformatf("rand%0d", i), e_grant, e_nums, e_blank,
                        e_switch);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
